// File: rtl/ev_bcd_display.sv
// ev_bcd_display: sequential double-dabble of an 8-bit count into three BCD digits,
// time-multiplexed onto one 7-segment output with leading-zero blanking.
module ev_bcd_display #(
  parameter int SCAN_DIV       = 1024,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  value_in,
  input  logic        value_valid,
  output logic        ready,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_sel
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t r_state, w_next;
  logic [19:0] r_shift, w_adj;
  logic [2:0] r_bitcnt;
  logic [11:0] r_bcd, r_disp;
  logic [SW-1:0] r_scan;
  logic [1:0] r_idx;
  logic w_load, w_blank;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'd0: f_seg = 7'h3F;
      4'd1: f_seg = 7'h06;
      4'd2: f_seg = 7'h5B;
      4'd3: f_seg = 7'h4F;
      4'd4: f_seg = 7'h66;
      4'd5: f_seg = 7'h6D;
      4'd6: f_seg = 7'h7D;
      4'd7: f_seg = 7'h07;
      4'd8: f_seg = 7'h7F;
      4'd9: f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else if (ena) r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    ready = 1'b0;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        w_load = ena && value_valid;
        w_next = w_load ? CONV : IDLE;
      end
      CONV: w_next = r_bitcnt == 3'd7 ? DONE : CONV;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // add-3 correction on each BCD nibble before the shift
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < 3; k++)
      w_adj[8+4*k +: 4] = r_shift[8+4*k +: 4] >= 4'd5 ? r_shift[8+4*k +: 4] + 4'd3 : r_shift[8+4*k +: 4];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bitcnt <= '0;
      r_bcd <= '0;
      r_disp <= '0;
    end else if (ena) begin
      if (w_load) begin
        r_shift <= {12'b0, value_in};
        r_bitcnt <= '0;
      end else if (r_state == CONV) begin
        r_shift <= w_adj << 1;
        r_bitcnt <= r_bitcnt + 3'd1;
      end else if (r_state == DONE) begin
        r_bcd <= r_shift[19:8];
        r_disp <= r_shift[19:8];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx <= '0;
    end else if (ena) begin
      r_scan <= r_scan == SCAN_MAX ? '0 : r_scan + SW'(1);
      if (r_scan == SCAN_MAX) r_idx <= r_idx == 2'd2 ? 2'd0 : r_idx + 2'd1;
    end
  end
  always_comb begin
    w_nib = r_idx == 2'd2 ? r_disp[11:8] : r_idx == 2'd1 ? r_disp[7:4] : r_disp[3:0];
    w_blank = (r_idx == 2'd2 && r_disp[11:8] == 4'd0) || (r_idx == 2'd1 && r_disp[11:4] == 8'd0);
    w_seg = w_blank ? 7'h00 : f_seg(w_nib);
    digit_sel = r_idx == 2'd2 ? 3'b100 : r_idx == 2'd1 ? 3'b010 : 3'b001;
  end
  assign seg = w_seg ^ {7{ACTIVE_LOW_SEG}};
  assign dp = ACTIVE_LOW_SEG;
  assign bcd_out = r_bcd;
endmodule

// File: tb/tb_ev_bcd_display.sv
// tb_ev_bcd_display: directed scenarios with a queue of expected BCD results
// and a reference model of the scan/segment/blanking behaviour.
module tb_ev_bcd_display;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, value_valid = 1'b0;
  logic [7:0] value_in = '0;
  logic ready, dp;
  logic [11:0] bcd_out;
  logic [6:0] seg;
  logic [2:0] digit_sel;
  int n_cmp = 0, n_err = 0;
  logic [11:0] q_exp[$];
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  ev_bcd_display #(.SCAN_DIV(4), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .value_in(value_in), .value_valid(value_valid),
    .ready(ready), .bcd_out(bcd_out), .seg(seg), .dp(dp), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic accept(input logic [7:0] v);
    value_in = v;
    value_valid = 1'b1;
    chk("ready_idle", {31'b0, ready}, 1);
    tick;
    value_valid = 1'b0;
    q_exp.push_back(to_bcd(int'(v)));
    chk("ready_drop", {31'b0, ready}, 0);
  endtask

  task automatic finish_conv(input string tag, input int exp_lat, input int pre);
    int n = pre;
    while (!ready && n < 40) begin tick; n++; end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_bcd"}, {20'b0, bcd_out}, {20'b0, q_exp.pop_front()});
  endtask

  task automatic scan_check(input int v);
    int n = 0;
    int dg[3];
    dg[0] = v % 10; dg[1] = (v / 10) % 10; dg[2] = v / 100;
    while (digit_sel !== 3'b100 && n < 40) begin tick; n++; end
    while (digit_sel !== 3'b001 && n < 40) begin tick; n++; end
    chk("scan_sync", {31'b0, n < 40}, 1);
    for (int i = 0; i < 12; i++) begin
      int d = i / 4;
      logic blank = (d == 2 && dg[2] == 0) || (d == 1 && dg[2] == 0 && dg[1] == 0);
      chk("scan_sel", {29'b0, digit_sel}, 32'(1 << d));
      chk("scan_seg", {25'b0, seg}, blank ? 32'h0 : {25'b0, seg_tab[dg[d]]});
      chk("dp_off", {31'b0, dp}, 0);
      tick;
    end
  endtask

  initial begin
    int n;
    logic [2:0] ds;
    tick; tick;
    rst_n = 1'b1;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_bcd", {20'b0, bcd_out}, 0);
    chk("rst_sel", {29'b0, digit_sel}, 1);
    chk("rst_seg", {25'b0, seg}, 32'h3F);
    chk("rst_dp", {31'b0, dp}, 0);
    accept(8'd255);
    finish_conv("v255", 9, 0);
    scan_check(255);
    accept(8'd7);
    finish_conv("v7", 9, 0);
    scan_check(7);
    accept(8'd100);
    finish_conv("v100", 9, 0);
    scan_check(100);
    accept(8'd42);
    tick;
    value_in = 8'd99;
    value_valid = 1'b1;
    tick; tick;
    value_valid = 1'b0;
    finish_conv("v42", 9, 3);
    value_in = 8'd99;
    value_valid = 1'b1;
    q_exp.push_back(to_bcd(99));
    n = 0;
    while (bcd_out === 12'h042 && n < 40) begin tick; n++; end
    value_valid = 1'b0;
    chk("hold_lat", n, 10);
    chk("hold_bcd", {20'b0, bcd_out}, {20'b0, q_exp.pop_front()});
    accept(8'd200);
    tick; tick;
    ena = 1'b0;
    ds = digit_sel;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("gap_sel", {29'b0, digit_sel}, {29'b0, ds});
      chk("gap_ready", {31'b0, ready}, 0);
    end
    ena = 1'b1;
    finish_conv("gap", 14, 7);
    accept(8'd123);
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    q_exp.delete();
    chk("abort_bcd", {20'b0, bcd_out}, 0);
    chk("abort_ready", {31'b0, ready}, 1);
    chk("abort_sel", {29'b0, digit_sel}, 1);
    chk("abort_seg", {25'b0, seg}, 32'h3F);
    accept(8'd58);
    finish_conv("after_rst", 9, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
